session_link_ctrl: RTL

- Parametrised next-generation transmit-side session controller for the AES link.
- Sequences long-key load, Diffie-Hellman session-key exchange and data transmission.
- Rotates session keys every REKEY_BLOCKS blocks; requests a long-key change after SESSIONS_PER_LONG_KEY sessions.
- Adds a DH timeout/retry path and a clean abort. The cipher, DH engine and key container sit outside and are reached through handshake ports.

---
 rtl/session_link_ctrl_pkg.sv | 20 ++
 rtl/session_link_ctrl_if.sv | 36 +++
 rtl/session_link_ctrl_block_counter.sv | 20 ++
 rtl/session_link_ctrl.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/session_link_ctrl_pkg.sv
// Shared types and constants for the AES link transmit-side session controller.
package session_link_ctrl_pkg;
  localparam int DATA_W_DEF = 128;
  localparam int CNT_W_DEF  = 32;
  localparam int STAT_W     = 16;

  localparam logic [2:0] S_IDLE        = 3'd0;
  localparam logic [2:0] S_KEY_EXCH    = 3'd1;
  localparam logic [2:0] S_TRANSMIT    = 3'd2;
  localparam logic [2:0] S_LONG_KEY_CH = 3'd3;
  localparam logic [2:0] S_ERROR       = 3'd4;

  typedef enum logic [2:0] {
    ST_IDLE        = S_IDLE,
    ST_KEY_EXCH    = S_KEY_EXCH,
    ST_TRANSMIT    = S_TRANSMIT,
    ST_LONG_KEY_CH = S_LONG_KEY_CH,
    ST_ERROR       = S_ERROR
  } state_e;
endpackage

// File: rtl/session_link_ctrl_if.sv
// Handshake bundle between the session controller and user/cipher/DH/key container.
// SESSION_LINK_STATS_EN adds the statistics counters to the bundle.
interface session_link_ctrl_if
  import session_link_ctrl_pkg::*;
#(parameter int DATA_W = DATA_W_DEF);
  logic              transmit_req, usr_long_key_ch, err_clr, data_stb, o_stb;
  logic              cipher_ready, dh_key_valid, cc_key_val;
  logic [DATA_W-1:0] dh_key, cc_key_out;
  logic              ready_for_transmit, ready, usr_long_key_valid;
  logic              usr_long_key_change_rq, session_err;
  logic [DATA_W-1:0] cur_key, cc_key_in;
  logic              cur_key_valid, dh_start, cc_sgn_key_ch;
`ifdef SESSION_LINK_STATS_EN
  logic [STAT_W-1:0] stat_rekeys, stat_retries;
`endif

  modport slave (
    input  transmit_req, usr_long_key_ch, err_clr, data_stb, o_stb,
    input  cipher_ready, dh_key, dh_key_valid, cc_key_out, cc_key_val,
    output ready_for_transmit, ready, usr_long_key_valid, usr_long_key_change_rq,
    output session_err, cur_key, cur_key_valid, dh_start, cc_sgn_key_ch, cc_key_in
`ifdef SESSION_LINK_STATS_EN
    , output stat_rekeys, stat_retries
`endif
  );

  modport master (
    output transmit_req, usr_long_key_ch, err_clr, data_stb, o_stb,
    output cipher_ready, dh_key, dh_key_valid, cc_key_out, cc_key_val,
    input  ready_for_transmit, ready, usr_long_key_valid, usr_long_key_change_rq,
    input  session_err, cur_key, cur_key_valid, dh_start, cc_sgn_key_ch, cc_key_in
`ifdef SESSION_LINK_STATS_EN
    , input stat_rekeys, stat_retries
`endif
  );
endinterface

// File: rtl/session_link_ctrl_block_counter.sv
// Clearable up-counter with an equality flag against a fixed limit.
module block_counter #(
  parameter int               CNT_W = 32,
  parameter logic [CNT_W-1:0] LIMIT = '1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             inc,
  output logic [CNT_W-1:0] count,
  output logic             at_limit
);
  always_ff @(posedge clk or posedge reset) begin
    if (reset)    count <= '0;
    else if (clr) count <= '0;
    else if (inc) count <= count + 1'b1;
  end

  assign at_limit = (count == LIMIT);
endmodule

// File: rtl/session_link_ctrl.sv
// Transmit-side session controller: long-key load, DH session-key exchange, rekeying.
// Optional statistics outputs are enabled by SESSION_LINK_STATS_EN.
module session_link_ctrl
  import session_link_ctrl_pkg::*;
#(
  parameter int                DATA_W                = DATA_W_DEF,
  parameter int                CNT_W                 = CNT_W_DEF,
  parameter logic [CNT_W-1:0]  REKEY_BLOCKS          = CNT_W'(32'hFFFF_FFFF),
  parameter int                SESSIONS_PER_LONG_KEY = 4,
  parameter int                DH_TIMEOUT            = 1024,
  parameter int                MAX_RETRY             = 3,
  parameter logic [DATA_W-1:0] INITIAL_LONG_KEY      = DATA_W'(130)
) (
  input  logic clk,
  input  logic reset,
  session_link_ctrl_if.slave bus
);
  localparam int TMR_W  = $clog2(DH_TIMEOUT + 1);
  localparam int RTY_W  = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);
  localparam int SESS_W = $clog2(SESSIONS_PER_LONG_KEY + 1);
  localparam logic [TMR_W-1:0]  TMO_LAST  = TMR_W'(DH_TIMEOUT - 1);
  localparam logic [RTY_W-1:0]  RTY_MAX   = RTY_W'(MAX_RETRY);
  localparam logic [SESS_W-1:0] SESS_LAST = SESS_W'(SESSIONS_PER_LONG_KEY);

  state_e            state, nxt_state;
  logic [DATA_W-1:0] cur_key, nxt_cur_key, key_in, nxt_key_in;
  logic              key_valid, nxt_key_valid, dh_start, nxt_dh_start;
  logic              sgn, nxt_sgn, rq, nxt_rq;
  logic [TMR_W-1:0]  timer, nxt_timer;
  logic [RTY_W-1:0]  retry, nxt_retry;
  logic [SESS_W-1:0] sess_cnt, nxt_sess;
  logic [CNT_W-1:0]  in_cnt, out_cnt;
  logic              in_full, out_last, cnt_clr, in_inc, out_inc, ready;

  assign ready   = (state == ST_TRANSMIT) && bus.cipher_ready && !in_full;
  assign in_inc  = ready && bus.data_stb;
  assign out_inc = (state == ST_TRANSMIT) && bus.o_stb && (out_cnt != in_cnt);

  block_counter #(.CNT_W(CNT_W), .LIMIT(REKEY_BLOCKS)) u_in_cnt (
    .clk(clk), .reset(reset), .clr(cnt_clr), .inc(in_inc),
    .count(in_cnt), .at_limit(in_full)
  );

  // Limit is one below REKEY_BLOCKS so the flag marks the o_stb that completes the session.
  block_counter #(.CNT_W(CNT_W), .LIMIT(REKEY_BLOCKS - CNT_W'(1))) u_out_cnt (
    .clk(clk), .reset(reset), .clr(cnt_clr), .inc(out_inc),
    .count(out_cnt), .at_limit(out_last)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= ST_IDLE;
      cur_key   <= '0;
      key_valid <= 1'b0;
      dh_start  <= 1'b0;
      sgn       <= 1'b0;
      rq        <= 1'b0;
      key_in    <= INITIAL_LONG_KEY;
      timer     <= '0;
      retry     <= '0;
      sess_cnt  <= '0;
    end else begin
      state     <= nxt_state;
      cur_key   <= nxt_cur_key;
      key_valid <= nxt_key_valid;
      dh_start  <= nxt_dh_start;
      sgn       <= nxt_sgn;
      rq        <= nxt_rq;
      key_in    <= nxt_key_in;
      timer     <= nxt_timer;
      retry     <= nxt_retry;
      sess_cnt  <= nxt_sess;
    end
  end

  always_comb begin
    nxt_state     = state;
    nxt_cur_key   = cur_key;
    nxt_key_valid = key_valid;
    nxt_dh_start  = 1'b0;
    nxt_sgn       = 1'b0;
    nxt_rq        = rq;
    nxt_key_in    = key_in;
    nxt_timer     = timer;
    nxt_retry     = retry;
    nxt_sess      = sess_cnt;
    cnt_clr       = 1'b0;
    case (state)
      ST_IDLE: if (bus.transmit_req && bus.cc_key_val) begin
        nxt_cur_key   = bus.cc_key_out;
        nxt_key_valid = 1'b1;
        nxt_dh_start  = 1'b1;
        nxt_timer     = '0;
        nxt_retry     = '0;
        nxt_state     = ST_KEY_EXCH;
      end
      ST_KEY_EXCH: begin
        if (bus.dh_key_valid) begin
          nxt_cur_key = bus.dh_key;
          cnt_clr     = 1'b1;
          // Saturates so an aborted final session still leads to a long-key change.
          nxt_sess    = (sess_cnt >= SESS_LAST) ? sess_cnt : sess_cnt + 1'b1;
          nxt_state   = ST_TRANSMIT;
        end else if (timer == TMO_LAST) begin
          if (retry < RTY_MAX) begin
            nxt_retry    = retry + 1'b1;
            nxt_timer    = '0;
            nxt_dh_start = 1'b1;
          end else begin
            nxt_key_valid = 1'b0;
            nxt_state     = ST_ERROR;
          end
        end else begin
          nxt_timer = timer + 1'b1;
        end
      end
      ST_TRANSMIT: begin
        if (out_inc && out_last) begin
          if (sess_cnt >= SESS_LAST) begin
            nxt_key_valid = 1'b0;
            nxt_rq        = 1'b1;
            nxt_state     = ST_LONG_KEY_CH;
          end else begin
            nxt_cur_key  = bus.cc_key_out;
            nxt_dh_start = 1'b1;
            nxt_timer    = '0;
            nxt_retry    = '0;
            nxt_state    = ST_KEY_EXCH;
          end
        end else if (!bus.transmit_req && (in_cnt == out_cnt)) begin
          nxt_key_valid = 1'b0;
          nxt_state     = ST_IDLE;
        end
      end
      ST_LONG_KEY_CH: begin
        if (bus.usr_long_key_ch && rq) begin
          nxt_sgn    = 1'b1;
          nxt_key_in = key_in + 1'b1;
          nxt_rq     = 1'b0;
        end
        if (bus.cc_key_val && !rq) begin
          nxt_sess  = '0;
          nxt_state = ST_IDLE;
        end
      end
      ST_ERROR: if (bus.err_clr) begin
        nxt_retry = '0;
        nxt_state = ST_IDLE;
      end
      default: nxt_state = ST_IDLE;
    endcase
  end

  assign bus.ready_for_transmit     = (state == ST_IDLE);
  assign bus.session_err            = (state == ST_ERROR);
  assign bus.ready                  = ready;
  assign bus.usr_long_key_valid     = bus.cc_key_val;
  assign bus.usr_long_key_change_rq = rq;
  assign bus.cur_key                = cur_key;
  assign bus.cur_key_valid          = key_valid;
  assign bus.dh_start               = dh_start;
  assign bus.cc_sgn_key_ch          = sgn;
  assign bus.cc_key_in              = key_in;

`ifdef SESSION_LINK_STATS_EN
  logic [STAT_W-1:0] stat_rekeys, stat_retries;
  logic              rekey_evt, retry_evt;

  assign rekey_evt = (state == ST_KEY_EXCH) && bus.dh_key_valid;
  assign retry_evt = (state == ST_KEY_EXCH) && !bus.dh_key_valid &&
                     (timer == TMO_LAST) && (retry < RTY_MAX);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stat_rekeys  <= '0;
      stat_retries <= '0;
    end else begin
      if (rekey_evt && stat_rekeys != '1)  stat_rekeys  <= stat_rekeys + 1'b1;
      if (retry_evt && stat_retries != '1) stat_retries <= stat_retries + 1'b1;
    end
  end

  assign bus.stat_rekeys  = stat_rekeys;
  assign bus.stat_retries = stat_retries;
`endif
endmodule
